// File: rtl/frame_compare.sv
`default_nettype none
// ============================================================================
// Module   : frame_compare
// Purpose  : Stores each RX frame in the frame BRAM and compares it byte by byte
//            with the frame stored there before it.
// Revision : 1.0 - initial release
// ============================================================================
module frame_compare #(
    parameter int MAX_LEN = 1501,
    parameter int ADDR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              rx_last,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic              bram_we,
    input  logic [7:0]        bram_dout,
    output logic              done,
    output logic              match,
    output logic              ref_valid,
    output logic [ADDR_W-1:0] mismatch_cnt,
    output logic [ADDR_W-1:0] frame_len,
    output logic              len_mismatch,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] c_MAX_LEN = ADDR_W'(MAX_LEN);
    localparam logic [ADDR_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_ready;
    logic              w_done;

    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_mm_run;
    logic              r_ovf_run;
    logic [ADDR_W-1:0] r_prev_len;
    logic              r_have_ref;
    logic              r_s1_valid;
    logic [7:0]        r_s1_data;

    logic              r_match;
    logic              r_ref_valid;
    logic [ADDR_W-1:0] r_mismatch_cnt;
    logic [ADDR_W-1:0] r_frame_len;
    logic              r_len_mismatch;
    logic              r_overflow;

    logic              w_accept;
    logic              w_inrange;
    logic              w_wr;
    logic              w_diff;
    logic [ADDR_W-1:0] w_mm_next;
    logic              w_len_mis;

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (rx_valid)
                    w_state_nxt = rx_last ? S_DRAIN : S_RUN;
            end
            S_RUN: begin
                w_ready = 1'b1;
                if (rx_valid && rx_last)
                    w_state_nxt = S_DRAIN;
            end
            S_DRAIN:  w_state_nxt = S_REPORT;
            S_REPORT: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept  = rx_valid & w_ready;
    assign w_inrange = (r_idx < c_MAX_LEN);
    assign w_wr      = w_accept & w_inrange;

    // bram_dout now holds the pre-write byte for the address driven last cycle
    assign w_diff    = r_s1_valid & (r_s1_data != bram_dout);
    assign w_mm_next = (w_diff && (r_mm_run != c_CNT_MAX)) ? r_mm_run + 1'b1 : r_mm_run;
    assign w_len_mis = r_have_ref & (r_idx != r_prev_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_mm_run       <= '0;
            r_ovf_run      <= 1'b0;
            r_prev_len     <= '0;
            r_have_ref     <= 1'b0;
            r_s1_valid     <= 1'b0;
            r_s1_data      <= 8'h00;
            r_match        <= 1'b0;
            r_ref_valid    <= 1'b0;
            r_mismatch_cnt <= '0;
            r_frame_len    <= '0;
            r_len_mismatch <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_s1_valid <= w_wr & (r_idx < r_prev_len);
            r_s1_data  <= rx_data;

            if (r_state == S_REPORT) begin
                r_prev_len <= r_idx;
                r_have_ref <= ~r_ovf_run;
                r_idx      <= '0;
                r_mm_run   <= '0;
                r_ovf_run  <= 1'b0;
            end else begin
                r_mm_run <= w_mm_next;
                if (w_accept) begin
                    if (w_inrange)
                        r_idx <= r_idx + 1'b1;
                    else
                        r_ovf_run <= 1'b1;
                end
            end

            // Final compare lands in DRAIN, so results are captured with it
            if (r_state == S_DRAIN) begin
                r_mismatch_cnt <= w_mm_next;
                r_frame_len    <= r_idx;
                r_overflow     <= r_ovf_run;
                r_ref_valid    <= r_have_ref;
                r_len_mismatch <= w_len_mis;
                r_match        <= r_have_ref & ~w_len_mis & ~r_ovf_run & (w_mm_next == '0);
            end
        end
    end

    assign rx_ready     = w_ready;
    assign done         = w_done;
    assign bram_we      = w_wr;
    assign bram_addr    = r_idx;
    assign bram_din     = w_wr ? rx_data : 8'h00;
    assign match        = r_match;
    assign ref_valid    = r_ref_valid;
    assign mismatch_cnt = r_mismatch_cnt;
    assign frame_len    = r_frame_len;
    assign len_mismatch = r_len_mismatch;
    assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_frame_compare.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_frame_compare
// Purpose  : Bench for frame_compare with a behavioural BRAM and frame model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_compare;

    localparam int MAX_LEN = 1501;
    localparam int ADDR_W  = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_last;
    logic              rx_ready;
    logic [ADDR_W-1:0] bram_addr;
    logic [7:0]        bram_din;
    logic              bram_we;
    logic [7:0]        bram_dout;
    logic              done;
    logic              match;
    logic              ref_valid;
    logic [ADDR_W-1:0] mismatch_cnt;
    logic [ADDR_W-1:0] frame_len;
    logic              len_mismatch;
    logic              overflow;

    frame_compare #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_last(rx_last), .rx_ready(rx_ready), .bram_addr(bram_addr),
        .bram_din(bram_din), .bram_we(bram_we), .bram_dout(bram_dout),
        .done(done), .match(match), .ref_valid(ref_valid),
        .mismatch_cnt(mismatch_cnt), .frame_len(frame_len),
        .len_mismatch(len_mismatch), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Read-before-write, 1-cycle latency BRAM port
    logic [7:0] bram_mem [0:4095];
    int         wr_cnt  = 0;
    int         bad_we  = 0;
    int         done_cnt = 0;
    always @(posedge clk) begin
        if (bram_we) begin
            bram_mem[bram_addr] <= bram_din;
            wr_cnt <= wr_cnt + 1;
            if (int'(bram_addr) >= MAX_LEN) bad_we <= bad_we + 1;
        end
        bram_dout <= bram_mem[bram_addr];
        if (done) done_cnt <= done_cnt + 1;
    end

    typedef struct {
        bit ref_v;
        bit match;
        bit lm;
        bit ovf;
        int flen;
        int mm;
    } res_t;

    typedef struct {
        int   len;
        bit   gaps;
        int   flip_a;
        int   flip_b;
        res_t exp;
    } vec_t;

    logic [7:0] fb    [0:1599];
    logic [7:0] m_mem [0:MAX_LEN-1];
    int         m_prev = 0;
    bit         m_have = 1'b0;
    int         n_pass = 0;
    int         n_total = 0;
    int         stalls = 0;

    // Frame-level reference: stored prefix, compare against previous stored frame
    function automatic res_t model_frame(input int n);
        res_t r;
        int   stored;
        stored  = (n > MAX_LEN) ? MAX_LEN : n;
        r.ovf   = (n > MAX_LEN);
        r.flen  = stored;
        r.ref_v = m_have;
        r.mm    = 0;
        for (int i = 0; i < stored && i < m_prev; i++)
            if (m_mem[i] != fb[i]) r.mm = r.mm + 1;
        r.lm    = m_have && (stored != m_prev);
        r.match = m_have && !r.lm && !r.ovf && (r.mm == 0);
        for (int i = 0; i < stored; i++) m_mem[i] = fb[i];
        m_prev = stored;
        m_have = !r.ovf;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit l);
        bit acc;
        acc      = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        rx_last  = l;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = rx_ready;
            if (!acc) stalls++;
            @(posedge clk); #1;
        end
        if (!acc) check("ready_timeout", 0, 1);
        rx_valid = 1'b0;
        rx_last  = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            send_byte(fb[i], i == n - 1);
        end
    endtask

    task automatic check_results(input res_t e);
        check("ref_valid", int'(ref_valid), int'(e.ref_v));
        check("match", int'(match), int'(e.match));
        check("len_mismatch", int'(len_mismatch), int'(e.lm));
        check("overflow", int'(overflow), int'(e.ovf));
        check("frame_len", int'(frame_len), e.flen);
        check("mismatch_cnt", int'(mismatch_cnt), e.mm);
    endtask

    task automatic run_frame(input int n, input bit gaps, input bit use_exp, input res_t exp_in);
        res_t m;
        res_t e;
        m = model_frame(n);
        e = use_exp ? exp_in : m;
        send_frame(n, gaps);
        check("done_early", int'(done), 0);
        @(posedge clk); #1;
        check("done_pulse", int'(done), 1);
        check_results(e);
        @(posedge clk); #1;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [0:8];
        res_t e;
        int   base_wr;
        int   base_bad;
        int   base_done;
        int   bad;
        int   n;

        vecs[0] = '{64,   1'b0, -1, -1, '{1'b0, 1'b0, 1'b0, 1'b0, 64,   0}};
        vecs[1] = '{64,   1'b1, -1, -1, '{1'b1, 1'b1, 1'b0, 1'b0, 64,   0}};
        vecs[2] = '{64,   1'b0,  5, 63, '{1'b1, 1'b0, 1'b0, 1'b0, 64,   2}};
        vecs[3] = '{64,   1'b1,  5, 63, '{1'b1, 1'b1, 1'b0, 1'b0, 64,   0}};
        vecs[4] = '{64,   1'b0, -1, -1, '{1'b1, 1'b0, 1'b0, 1'b0, 64,   2}};
        vecs[5] = '{60,   1'b0, -1, -1, '{1'b1, 1'b0, 1'b1, 1'b0, 60,   0}};
        vecs[6] = '{60,   1'b1, -1, -1, '{1'b1, 1'b1, 1'b0, 1'b0, 60,   0}};
        vecs[7] = '{1600, 1'b0, -1, -1, '{1'b1, 1'b0, 1'b1, 1'b1, 1501, 0}};
        vecs[8] = '{64,   1'b0, -1, -1, '{1'b0, 1'b0, 1'b0, 1'b0, 64,   0}};

        for (int i = 0; i < 4096; i++) bram_mem[i] = 8'h00;
        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_last  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rx_ready", int'(rx_ready), 1);
        check("rst_bram_we", int'(bram_we), 0);
        check("rst_bram_addr", int'(bram_addr), 0);
        check("rst_done", int'(done), 0);
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        check_results(e);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 9; v++) begin
            for (int i = 0; i < vecs[v].len; i++) fb[i] = 8'(i + 1);
            if (vecs[v].flip_a >= 0) fb[vecs[v].flip_a] = ~fb[vecs[v].flip_a];
            if (vecs[v].flip_b >= 0) fb[vecs[v].flip_b] = ~fb[vecs[v].flip_b];
            stalls   = 0;
            base_wr  = wr_cnt;
            base_bad = bad_we;
            run_frame(vecs[v].len, vecs[v].gaps, 1'b1, vecs[v].exp);
            if (v == 0) begin
                check("ready_stalls", stalls, 0);
                bad = 0;
                for (int i = 0; i < 64; i++) if (bram_mem[i] != 8'(i + 1)) bad++;
                check("bram_contents", bad, 0);
            end
            if (v == 7) begin
                check("ovf_bad_we", bad_we - base_bad, 0);
                check("ovf_writes", wr_cnt - base_wr, MAX_LEN);
            end
        end

        // Reset in the middle of a frame
        for (int i = 0; i < 64; i++) fb[i] = 8'(i + 1);
        base_done = done_cnt;
        for (int i = 0; i < 30; i++) send_byte(fb[i], 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_rx_ready", int'(rx_ready), 1);
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
        check_results(e);
        repeat (4) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - base_done, 0);
        m_prev = 0;
        m_have = 1'b0;
        e = '{1'b0, 1'b0, 1'b0, 1'b0, 64, 0};
        run_frame(64, 1'b0, 1'b1, e);

        // Byte offered right after rx_last waits for IDLE
        e = model_frame(64);
        for (int i = 0; i < 64; i++) send_byte(fb[i], i == 63);
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        rx_last  = 1'b1;
        check("b2b_ready_drain", int'(rx_ready), 0);
        check("b2b_we_drain", int'(bram_we), 0);
        @(posedge clk); #1;
        check("b2b_ready_report", int'(rx_ready), 0);
        check("b2b_done", int'(done), 1);
        check("b2b_match", int'(match), int'(e.match));
        @(posedge clk); #1;
        check("b2b_ready_idle", int'(rx_ready), 1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        fb[0] = 8'hAA;
        e = model_frame(1);
        @(posedge clk); #1;
        check("b2b_single_done", int'(done), 1);
        check_results(e);
        @(posedge clk); #1;

        // Randomized frames against the model
        n = 1;
        for (int r = 0; r < 12; r++) begin
            if (r > 0 && ($urandom_range(0, 1) == 1)) begin
                if ($urandom_range(0, 1) == 1) begin
                    int idx;
                    idx = $urandom_range(0, n - 1);
                    fb[idx] = ~fb[idx];
                end
            end else begin
                n = $urandom_range(1, 100);
                for (int i = 0; i < n; i++) fb[i] = 8'($urandom_range(0, 255));
            end
            e = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
            run_frame(n, $urandom_range(0, 1) == 1, 1'b0, e);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_compare.md
Name: frame_compare

Overview:
- Downstream consumer of the RX byte stream; sits in front of the 8-bit true dual-port frame BRAM (1501 x 8, 1-cycle read, read-before-write per port) and drives one of its ports.
- For each received frame, writes byte i to BRAM address i and, in the same access, reads back the byte stored there by the previous frame.
- Compares the two byte by byte and reports match/mismatch, the mismatch count and the lengths. Used to check redundant transmissions.

Parameters:
- MAX_LEN, 1501, maximum stored frame bytes; must not exceed BRAM depth.
- ADDR_W, 12, BRAM address width.

Ports:
- clk  in  1  single clock; the BRAM port is on the same clock.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  byte on rx_data is valid.
- rx_data  in  8  received byte.
- rx_last  in  1  qualifies the final byte of the frame; sampled only with rx_valid.
- rx_ready  out  1  block accepts the byte; transfer = rx_valid & rx_ready.
- bram_addr  out  ADDR_W  BRAM port address.
- bram_din  out  8  BRAM write data.
- bram_we  out  1  BRAM write enable.
- bram_dout  in  8  BRAM read data; valid 1 cycle after the address is driven, returns pre-write contents.
- done  out  1  1-cycle pulse; result outputs are updated in the same cycle.
- match  out  1  frame identical to the previous frame.
- ref_valid  out  1  a previous complete frame existed when this frame was compared.
- mismatch_cnt  out  ADDR_W  byte positions that differed.
- frame_len  out  ADDR_W  bytes accepted this frame, saturated at MAX_LEN.
- len_mismatch  out  1  frame_len differs from the previous frame_len.
- overflow  out  1  frame exceeded MAX_LEN bytes.

Behaviour:
- Reset values: rx_ready=1, bram_we=0, bram_addr=0, bram_din=0, done=0, match=0, ref_valid=0, mismatch_cnt=0, frame_len=0, len_mismatch=0, overflow=0. Internal prev_len=0 and have_ref=0. Reset mid-frame aborts the frame: no done, have_ref cleared.
- States:
  - IDLE to RUN on the first accepted byte.
  - RUN to DRAIN on an accepted byte with rx_last=1.
  - DRAIN to REPORT after 1 cycle.
  - REPORT to IDLE after 1 cycle.
- rx_ready is 1 in IDLE and RUN, 0 in DRAIN and REPORT. Minimum inter-frame gap is therefore 2 cycles.
- Accepted byte at index i (i < MAX_LEN), cycle t:
  - Drive bram_addr=i, bram_din=rx_data, bram_we=1.
  - Register rx_data and a compare-valid flag into stage 1.
  - bram_we is 0 in every cycle without an accepted in-range byte. rx_valid gaps are allowed.
- Cycle t+1: if the stage-1 flag is set and i < prev_len, compare the stage-1 byte with bram_dout. On inequality, increment mismatch_cnt, saturating at 2^ADDR_W-1. Positions with i >= prev_len are not compared.
- Index i >= MAX_LEN: no BRAM write, no compare, overflow set. The byte counter saturates at MAX_LEN; bytes are still accepted until rx_last.
- Result timing: for a last byte accepted in cycle t, the final compare happens at t+1 (DRAIN) and done pulses at t+2 (REPORT).
- Results at done:
  - ref_valid = have_ref.
  - len_mismatch = have_ref & (frame_len != prev_len).
  - match = have_ref & !len_mismatch & !overflow & (mismatch_cnt==0).
- After done:
  - prev_len <= frame_len; have_ref <= !overflow.
  - The running counters clear in IDLE. The result outputs hold until the next done.
- Single-byte frames (rx_last on the first byte) are legal.
- frame_len=0 never occurs.

Test Plan:
- After reset, send frame 0x01..0x40 (64 B) -> rx_ready=1 throughout; done 2 cycles after the last byte; ref_valid=0, match=0, frame_len=64, mismatch_cnt=0; BRAM[0..63]=0x01..0x40.
- Repeat an identical 64 B frame with random rx_valid gaps -> done with ref_valid=1, match=1, mismatch_cnt=0, len_mismatch=0.
- Same frame with bytes 5 and 63 inverted -> match=0, mismatch_cnt=2. A third identical copy of that frame -> match=1.
- 60 B frame after a 64 B frame -> len_mismatch=1, match=0, mismatch_cnt=0 if the prefix matches. A following 60 B copy -> match=1.
- 1600 B frame -> overflow=1, frame_len=1501, match=0, no bram_we for indices >= 1501. Next frame reports ref_valid=0.
- Assert rst mid-frame at byte 30, then send a full frame -> no done for the aborted frame; the new frame reports ref_valid=0. Offering a byte in the cycle right after rx_last -> rx_ready=0 for 2 cycles, byte not accepted until IDLE.
